// File: rtl/line_burst_pkg.sv
// Shared types and sizing helpers for the cache-line burst port.
package line_burst_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WBURST,
    RBURST,
    RESP
  } state_t;

  function automatic int calcBeats(int lineBytes, int busW);
    return lineBytes * 8 / busW;
  endfunction

  localparam int BEATS = calcBeats(16, 16);

endpackage

// File: rtl/line_burst_port_if.sv
// Cache request/response and memory burst signals of the line port.
// slave = the port itself, master = the cache/memory environment.
interface line_burst_port_if #(
  parameter int LINE_ADDR_W = 15,
  parameter int LINE_BYTES  = 16,
  parameter int BUS_W       = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [LINE_ADDR_W-1:0]  req_addr;
  logic [LINE_BYTES*8-1:0] req_wdata;
  logic                    resp_valid;
  logic [LINE_BYTES*8-1:0] resp_rdata;
  logic                    resp_err;
  logic [1:0]              mem_cmd;
  logic [LINE_ADDR_W-1:0]  mem_addr;
  logic [BUS_W-1:0]        mem_wdata;
  logic                    mem_wready;
  logic                    mem_rvalid;
  logic [BUS_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_wready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_cmd, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_wready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_cmd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/line_burst_port_buffer.sv
// Line register: parallel load at acceptance, beat select for writes,
// slot write for read beats.
module burst_line_buffer #(
  parameter int BEATS = 8,
  parameter int BUS_W = 16,
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LINE_W = BEATS * BUS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] loadData,
  input  logic              wrEn,
  input  logic [CNT_W-1:0]  slot,
  input  logic [BUS_W-1:0]  wrData,
  output logic [BUS_W-1:0]  beatData,
  output logic [LINE_W-1:0] lineMerged
);
  logic [BEATS-1:0][BUS_W-1:0] line, merged;

  // merged lets the top capture a completed read in the same cycle as its last beat
  always_comb begin
    merged       = line;
    merged[slot] = wrData;
  end

  assign beatData   = line[slot];
  assign lineMerged = merged;

  always_ff @(posedge clk) begin
    if (reset)     line <= '0;
    else if (load) line <= loadData;
    else if (wrEn) line <= merged;
  end
endmodule

// File: rtl/line_burst_port.sv
// Whole-line cache request to narrow memory burst engine.
// Optional BURST_TIMEOUT_EN: abort a stalled burst with resp_err.
module line_burst_port
  import line_burst_pkg::*;
#(
  parameter int LINE_ADDR_W = 15,
  parameter int LINE_BYTES  = 16,
  parameter int BUS_W       = 16,
  parameter int TIMEOUT     = 64
) (
  input logic              clk,
  input logic              reset,
  line_burst_port_if.slave bus
);
  localparam int BEATS_P = calcBeats(LINE_BYTES, BUS_W);
  localparam int CNT_W   = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;

  if (TIMEOUT < 2 || BEATS_P < 1) begin : gParamCheck
    $error("line_burst_port: bad TIMEOUT or bus/line geometry");
  end

  state_t                  state, stateNext;
  mem_cmd_t                cmd;
  logic [CNT_W-1:0]        beatCnt;
  logic [LINE_ADDR_W-1:0]  addrQ;
  logic                    writeQ;
  logic [LINE_BYTES*8-1:0] rdataQ, lineMerged;
  logic [BUS_W-1:0]        beatData;
  logic                    accept, wBeat, rBeat, lastBeat, timeoutHit;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign wBeat    = (state == WBURST) && bus.mem_wready;
  assign rBeat    = (state == RBURST) && bus.mem_rvalid;
  assign lastBeat = (beatCnt == CNT_W'(BEATS_P - 1));

`ifdef BURST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idleCnt;
  logic            errQ;

  // idleCnt = cycles since the last beat (or since CMD), so RESP lands TIMEOUT cycles after it
  assign timeoutHit = ((state == WBURST) || (state == RBURST)) && !(wBeat || rBeat)
                      && (idleCnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idleCnt <= '0;
      errQ    <= 1'b0;
    end else begin
      if (accept)              idleCnt <= '0;
      else if (wBeat || rBeat) idleCnt <= TO_W'(1);
      else if (state != IDLE)  idleCnt <= idleCnt + 1'b1;
      if (accept)          errQ <= 1'b0;
      else if (timeoutHit) errQ <= 1'b1;
    end
  end

  assign bus.resp_err = (state == RESP) && errQ;
`else
  assign timeoutHit   = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    cmd       = NOP;
    unique case (state)
      IDLE:    if (bus.req_valid) stateNext = CMD;
      CMD: begin
        cmd       = writeQ ? WRITE : READ;
        stateNext = writeQ ? WBURST : RBURST;
      end
      WBURST:  if ((wBeat && lastBeat) || timeoutHit) stateNext = RESP;
      RBURST:  if ((rBeat && lastBeat) || timeoutHit) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beatCnt <= '0;
      addrQ   <= '0;
      writeQ  <= 1'b0;
      rdataQ  <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        writeQ  <= bus.req_write;
        addrQ   <= bus.req_addr;
        beatCnt <= '0;
      end else if ((wBeat || rBeat) && !lastBeat) begin
        beatCnt <= beatCnt + 1'b1;
      end
      if (rBeat && lastBeat) rdataQ <= lineMerged;
    end
  end

  burst_line_buffer #(.BEATS(BEATS_P), .BUS_W(BUS_W)) uBuf (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .loadData  (bus.req_wdata),
    .wrEn      (rBeat),
    .slot      (beatCnt),
    .wrData    (bus.mem_rdata),
    .beatData  (beatData),
    .lineMerged(lineMerged)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdataQ;
  assign bus.mem_cmd    = cmd;
  assign bus.mem_addr   = addrQ;
  assign bus.mem_wdata  = beatData;
endmodule

// File: tb/tb_line_burst_port.sv
// Scoreboard bench for line_burst_port: write, read with waits, busy hold,
// mid-burst reset and memory stall (timeout or indefinite wait).
module tb_line_burst_port;
  localparam int LAW = 15, LB = 16, BW = 16, BEATS = 8, LW = LB * 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_burst_port_if #(.LINE_ADDR_W(LAW), .LINE_BYTES(LB), .BUS_W(BW)) bus();

  line_burst_port #(.LINE_ADDR_W(LAW), .LINE_BYTES(LB), .BUS_W(BW), .TIMEOUT(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0, checks = 0;
  logic [BW-1:0] beatQ[$];
  logic [LW-1:0] respQ[$];
  logic [LW-1:0] lastRead = '0;

  task automatic idleInputs();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_wready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1; idleInputs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got v=%b e=%b want 0/0", bus.resp_valid, bus.resp_err); end
    checks++; if (bus.mem_cmd !== 2'b00) begin errors++; $display("FAIL reset_cmd got %b want 00", bus.mem_cmd); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_mem got a=%h d=%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.resp_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [LW-1:0] line = 128'h00FF_EEDD_CCBB_AA99_8877_6655_4433_2211;
    logic [BW-1:0] exp;
    for (int i = 0; i < BEATS; i++) beatQ.push_back(line[i*BW +: BW]);
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 15'h0123; bus.req_wdata = line;
    bus.mem_wready = 1;
    for (int cyc = 0; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", bus.req_ready); end
      end
      if (cyc == 1) begin
        checks++; if (bus.mem_cmd !== 2'b10 || bus.mem_addr !== 15'h0123) begin errors++; $display("FAIL wr_cmd got %b/%h want 10/0123", bus.mem_cmd, bus.mem_addr); end
      end
      if (cyc >= 2 && cyc <= 9) begin
        checks++;
        if (beatQ.size() == 0) begin errors++; $display("FAIL wr_beat cycle %0d got extra beat %h want none", cyc, bus.mem_wdata); end
        else begin
          exp = beatQ.pop_front();
          if (bus.mem_wdata !== exp || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL wr_beat cycle %0d got %h v=%b want %h v=0", cyc, bus.mem_wdata, bus.resp_valid, exp); end
        end
      end
      if (cyc == 10) begin
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL wr_resp got v=%b e=%b want 1/0", bus.resp_valid, bus.resp_err); end
      end
      if (cyc == 11) begin
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL wr_done got r=%b v=%b want 1/0", bus.req_ready, bus.resp_valid); end
        checks++; if (bus.resp_rdata !== lastRead) begin errors++; $display("FAIL wr_rdata_hold got %h want %h", bus.resp_rdata, lastRead); end
      end
      @(posedge clk); #1;
      if (cyc == 0) begin bus.req_valid = 0; bus.req_addr = '1; bus.req_wdata = '1; end
    end
    bus.mem_wready = 0;
  endtask

  task automatic test_read_waits();
    logic [LW-1:0] line, got;
    int k = 0, respCyc = -1;
    for (int i = 0; i < BEATS; i++) line[i*BW +: BW] = BW'(i + 1);
    respQ.push_back(line);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 15'h7FFF; bus.mem_wready = 1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc <= 1) begin bus.mem_rvalid = 1; bus.mem_rdata = 16'hDEAD; end
      else if ((cyc % 2) == 0 && k < BEATS) begin bus.mem_rvalid = 1; bus.mem_rdata = BW'(k + 1); k++; end
      else begin bus.mem_rvalid = 0; bus.mem_rdata = 16'hBEEF; end
      @(negedge clk);
      if (cyc == 1) begin
        checks++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 15'h7FFF) begin errors++; $display("FAIL rd_cmd got %b/%h want 01/7fff", bus.mem_cmd, bus.mem_addr); end
      end
      if (bus.resp_valid === 1'b1 && respCyc < 0) begin
        respCyc = cyc;
        got = respQ.size() ? respQ.pop_front() : '0;
        checks++; if (bus.resp_rdata !== got || bus.resp_err !== 1'b0) begin errors++; $display("FAIL rd_data got %h e=%b want %h e=0", bus.resp_rdata, bus.resp_err, got); end
        lastRead = got;
      end
      @(posedge clk); #1;
      if (cyc == 0) bus.req_valid = 0;
      if (respCyc >= 0) break;
    end
    bus.mem_rvalid = 0; bus.mem_wready = 0;
    checks++; if (respCyc != 17) begin errors++; $display("FAIL rd_latency got cycle %0d want 17", respCyc); end
    respQ.delete();
  endtask

  task automatic test_busy_hold();
    logic [LW-1:0] lineA = {8{16'h1A2B}} ^ 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    logic [LW-1:0] lineB = {8{16'hC3D4}} ^ 128'h0070_0060_0050_0040_0030_0020_0010_0000;
    logic [BW-1:0] exp;
    for (int i = 0; i < BEATS; i++) beatQ.push_back(lineA[i*BW +: BW]);
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 15'h0456; bus.req_wdata = lineA;
    bus.mem_wready = 1;
    for (int cyc = 0; cyc <= 22; cyc++) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 10) begin
        checks++; if (bus.req_ready !== 1'b0 || bus.mem_addr !== 15'h0456) begin errors++; $display("FAIL busy_hold cycle %0d got r=%b a=%h want 0/0456", cyc, bus.req_ready, bus.mem_addr); end
      end
      if ((cyc >= 2 && cyc <= 9) || (cyc >= 13 && cyc <= 20)) begin
        checks++;
        if (beatQ.size() == 0) begin errors++; $display("FAIL busy_beat cycle %0d got extra beat %h want none", cyc, bus.mem_wdata); end
        else begin
          exp = beatQ.pop_front();
          if (bus.mem_wdata !== exp) begin errors++; $display("FAIL busy_beat cycle %0d got %h want %h", cyc, bus.mem_wdata, exp); end
        end
      end
      if (cyc == 10 || cyc == 21) begin
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL busy_resp cycle %0d got %b want 1", cyc, bus.resp_valid); end
      end
      if (cyc == 11) begin
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL busy_reaccept got %b want 1", bus.req_ready); end
        for (int i = 0; i < BEATS; i++) beatQ.push_back(lineB[i*BW +: BW]);
      end
      if (cyc == 12) begin
        checks++; if (bus.mem_cmd !== 2'b10 || bus.mem_addr !== 15'h0789) begin errors++; $display("FAIL busy_second got %b/%h want 10/0789", bus.mem_cmd, bus.mem_addr); end
      end
      if (cyc == 22) begin
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_rdata !== lastRead) begin errors++; $display("FAIL busy_end got r=%b d=%h want 1/%h", bus.req_ready, bus.resp_rdata, lastRead); end
      end
      @(posedge clk); #1;
      if (cyc == 4) begin bus.req_addr = 15'h0789; bus.req_wdata = lineB; end
      if (cyc == 11) bus.req_valid = 0;
    end
    bus.mem_wready = 0;
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] line;
    int spurious = 0, respCyc = -1;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 15'h0100;
    for (int cyc = 0; cyc <= 27; cyc++) begin
      bus.mem_rvalid = (cyc >= 2 && cyc <= 6); bus.mem_rdata = BW'(16'h10 + cyc);
      reset = (cyc == 6);
      @(negedge clk);
      if (cyc == 7) begin
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_cmd !== 2'b00 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got r=%b c=%b v=%b want 1/00/0", bus.req_ready, bus.mem_cmd, bus.resp_valid); end
        checks++; if (bus.resp_rdata !== '0) begin errors++; $display("FAIL rst_mid_rdata got %h want 0", bus.resp_rdata); end
      end
      if (bus.resp_valid === 1'b1) spurious++;
      @(posedge clk); #1;
      if (cyc == 0) bus.req_valid = 0;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rst_no_resp got %0d responses want 0", spurious); end
    lastRead = '0;
    for (int i = 0; i < BEATS; i++) line[i*BW +: BW] = BW'(16'hA0 + i);
    respQ.push_back(line);
    bus.req_valid = 1; bus.req_addr = 15'h0055;
    for (int cyc = 0; cyc <= 30; cyc++) begin
      bus.mem_rvalid = (cyc >= 2 && cyc <= 9); bus.mem_rdata = BW'(16'hA0 + cyc - 2);
      @(negedge clk);
      if (bus.resp_valid === 1'b1 && respCyc < 0) begin
        respCyc = cyc;
        line = respQ.size() ? respQ.pop_front() : '0;
        checks++; if (bus.resp_rdata !== line) begin errors++; $display("FAIL rst_after_data got %h want %h", bus.resp_rdata, line); end
        lastRead = line;
      end
      @(posedge clk); #1;
      if (cyc == 0) bus.req_valid = 0;
      if (respCyc >= 0) break;
    end
    bus.mem_rvalid = 0;
    checks++; if (respCyc != 10) begin errors++; $display("FAIL rst_after_latency got cycle %0d want 10", respCyc); end
  endtask

  task automatic test_stall();
    logic [LW-1:0] line;
    int respCyc = -1, lastCyc, resumeCyc;
`ifdef BURST_TIMEOUT_EN
    lastCyc = 120; resumeCyc = 100000;
`else
    lastCyc = 1100; resumeCyc = 1000;
`endif
    for (int i = 0; i < BEATS; i++) line[i*BW +: BW] = BW'(16'hB0 + i);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 15'h0200;
    for (int cyc = 0; cyc <= lastCyc; cyc++) begin
      if (cyc >= 2 && cyc <= 5) begin bus.mem_rvalid = 1; bus.mem_rdata = BW'(16'hB0 + cyc - 2); end
      else if (cyc >= resumeCyc && cyc < resumeCyc + 4) begin bus.mem_rvalid = 1; bus.mem_rdata = BW'(16'hB4 + cyc - resumeCyc); end
      else begin bus.mem_rvalid = 0; bus.mem_rdata = 16'hDEAD; end
      @(negedge clk);
      if (cyc == resumeCyc - 1) begin
        checks++; if (bus.req_ready !== 1'b0 || bus.mem_cmd !== 2'b00 || respCyc >= 0) begin errors++; $display("FAIL stall_wait got r=%b c=%b resp=%0d want 0/00/-1", bus.req_ready, bus.mem_cmd, respCyc); end
      end
      if (bus.resp_valid === 1'b1 && respCyc < 0) begin
        respCyc = cyc;
`ifdef BURST_TIMEOUT_EN
        checks++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== lastRead) begin errors++; $display("FAIL stall_timeout got e=%b d=%h want 1/%h", bus.resp_err, bus.resp_rdata, lastRead); end
`else
        checks++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== line) begin errors++; $display("FAIL stall_resume got e=%b d=%h want 0/%h", bus.resp_err, bus.resp_rdata, line); end
`endif
      end
      @(posedge clk); #1;
      if (cyc == 0) bus.req_valid = 0;
      if (respCyc >= 0) break;
    end
    bus.mem_rvalid = 0;
`ifdef BURST_TIMEOUT_EN
    checks++; if (respCyc != 69) begin errors++; $display("FAIL stall_timeout_cycle got %0d want 69", respCyc); end
`else
    checks++; if (respCyc != resumeCyc + 4) begin errors++; $display("FAIL stall_resume_cycle got %0d want %0d", respCyc, resumeCyc + 4); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_waits();
    test_busy_hold();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_burst_port.md
# line_burst_port

Line-transfer port between the cache and main memory. Accepts one whole-line read or write request from the cache and runs it as a burst of narrow beats on the memory bus, with a command phase, a beat counter and per-beat handshakes. For reads, it reassembles the line and returns it to the cache as a single response.

## Interface
Parameters:
- LINE_ADDR_W, 15, line address width (byte address without the offset bits)
- LINE_BYTES, 16, cache line size in bytes
- BUS_W, 16, memory data bus width; BEATS = LINE_BYTES*8/BUS_W (8 by default)
- TIMEOUT, 64, maximum idle cycles per beat (used only with the timeout feature)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  cache requests a line transfer
- req_ready  out  1  port idle, request can be accepted
- req_write  in  1  1 = write line, 0 = read line
- req_addr  in  LINE_ADDR_W  line address
- req_wdata  in  LINE_BYTES*8  line data for writes
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  LINE_BYTES*8  assembled line (reads); holds last value otherwise
- resp_err  out  1  qualifies resp_valid; transfer aborted
- mem_cmd  out  2  00 NOP, 01 READ, 10 WRITE
- mem_addr  out  LINE_ADDR_W  line address, valid with mem_cmd
- mem_wdata  out  BUS_W  current write beat
- mem_wready  in  1  memory accepts mem_wdata this cycle
- mem_rvalid  in  1  mem_rdata carries a read beat this cycle
- mem_rdata  in  BUS_W  read beat

## Operation
States:
- IDLE
  - req_ready=1.
  - On req_valid: latch req_write, req_addr and req_wdata; clear the beat counter; go to CMD.
- CMD
  - Drive mem_cmd=READ or WRITE and mem_addr for exactly one cycle.
  - Next state is WBURST for writes, RBURST for reads.
- WBURST
  - mem_wdata = beat k = line[k*BUS_W +: BUS_W]. Beat 0 is the least significant.
  - Each cycle with mem_wready=1 accepts beat k and increments k.
  - On acceptance of beat BEATS-1, go to RESP.
- RBURST
  - Each cycle with mem_rvalid=1 stores mem_rdata into slot k and increments k.
  - On beat BEATS-1, go to RESP.
- RESP
  - resp_valid=1 for one cycle, with resp_err as determined by the transfer.
  - Go to IDLE.

Rules:
- Beat counter: log2(BEATS) bits, counts 0..BEATS-1, no wrap. It is cleared on entry to CMD.
- mem_wready is ignored outside WBURST; mem_rvalid is ignored outside RBURST.
- Request inputs are sampled only at acceptance. Later changes have no effect.
- req_valid while busy: req_ready=0 and nothing is accepted. The cache must hold the request.
- resp_rdata updates only on read completion. Write responses leave it unchanged.

## Timing
- Reset values:
  - state IDLE, req_ready=1, resp_valid=0, resp_err=0, mem_cmd=NOP.
  - mem_addr=0, mem_wdata=0, resp_rdata=0, beat counter 0.
- Reset asserted mid-burst: at the next edge, return to IDLE and drive mem_cmd=NOP. Partial data is discarded and no response is issued.
- Cycle schedule with acceptance at cycle 0:
  - cycle 1: mem_cmd active.
  - cycle 2 onward: first beat may transfer.
  - With zero-wait memory, beats occupy cycles 2..9 and resp_valid occurs at cycle 10.
  - req_ready is high again at cycle 11.
- Each wait cycle (mem_wready=0 or mem_rvalid=0) adds exactly one cycle.
- req_ready is combinational from state only. There is no input-to-output combinational path.

## Configuration
BURST_TIMEOUT_EN:
- Defined:
  - A per-beat idle counter is cleared on each transferred beat and on CMD entry.
  - If it reaches TIMEOUT in WBURST or RBURST, go to RESP with resp_err=1.
  - resp_rdata is not updated in this case.
- Undefined:
  - The counter is absent and resp_err is tied to 0.
  - The port waits indefinitely for memory.

## Structure
- Package line_burst_pkg:
  - mem_cmd_t enum (NOP/READ/WRITE with the encodings above).
  - state_t enum (IDLE, CMD, WBURST, RBURST, RESP).
  - BEATS as a localparam function of the parameters.
- One sub-module, burst_line_buffer, holding the line register:
  - parallel load on acceptance;
  - beat-select output for writes;
  - slot write on each read beat.
- The FSM, beat counter and timeout counter stay in the top module.

## Test plan
- Write, addr 0x0123, data 0x00FF_EEDD_CCBB_AA99_8877_6655_4433_2211, mem_wready always 1:
  - mem_cmd=WRITE at cycle 1.
  - Beats 0x2211, 0x4433, …, 0x00FF on cycles 2..9.
  - resp_valid at cycle 10 with resp_err=0.
- Read, addr 0x7FFF, memory returns beats 0x0001..0x0008 with one wait cycle between beats:
  - resp_rdata = 0x0008_0007_…_0001.
  - resp_valid at cycle 17.
- req_valid held high during a burst with req_addr changed mid-burst:
  - No second acceptance until the cycle after resp_valid.
  - mem_addr is unchanged throughout.
- Reset asserted at beat 4 of a read:
  - Next cycle: IDLE, mem_cmd=NOP, req_ready=1.
  - No resp_valid is ever produced.
  - A following read completes correctly.
- With BURST_TIMEOUT_EN and TIMEOUT=64, memory stalls after beat 3 of a read:
  - resp_valid=1 and resp_err=1 exactly 64 cycles after beat 3.
  - resp_rdata is unchanged.
  - Without the macro, the port is still in RBURST after 1000 cycles.
